spi_byte_rx: RTL and testbench
==============================

# spi_byte_rx

SPI slave byte receiver in front of `spi_controller`. It synchronises the external SPI pins (`sclk`, `cs_n`, `mosi`) into the `clk` domain and deserialises MOSI into 8-bit bytes. For each completed byte it presents the byte on `spi_dout` with a one-cycle `spi_done` strobe. These two outputs connect directly to the identically named `spi_controller` inputs, which load `din`, `win` and `bias` from them.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop depth of each pin synchroniser. Legal values 2–4.
- `MSB_FIRST`, default 1: bit order. 1 = first received bit is bit 7; 0 = first received bit is bit 0.

Ports:
- `clk`  in  1: system clock. All logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `sclk`  in  1: SPI clock, asynchronous to `clk`. Mode 0 (CPOL=0, CPHA=0).
- `cs_n`  in  1: SPI chip select, active low, asynchronous.
- `mosi`  in  1: SPI data in, asynchronous.
- `spi_dout`  out  8: last completed byte. Held until the next byte completes.
- `spi_done`  out  1: one-cycle strobe. `spi_dout` is valid in the same cycle.
- `frame_err`  out  1: one-cycle strobe when `cs_n` rises with a partial byte in the shift register.
- `miso`  out  1: present only with `SPI_ECHO_EN` (see Configuration).

## Operation
- Each of `sclk`, `cs_n` and `mosi` passes through `SYNC_STAGES` flops, giving `sclk_s`, `cs_s`, `mosi_s`.
- One further flop, `sclk_d`, holds the previous value of `sclk_s`.
- `rise = sclk_s & ~sclk_d`. `fall = ~sclk_s & sclk_d`.
- FSM has two states:
  - IDLE: `bit_cnt`=0. Move to SHIFT when `cs_s`=0.
  - SHIFT: on each `rise`, shift `mosi_s` into the 8-bit `shreg` and increment the 3-bit `bit_cnt`.
    - When `rise` occurs with `bit_cnt`=7, the next edge sets `spi_dout` to the completed byte and pulses `spi_done` for one cycle. `bit_cnt` wraps to 0 and the FSM stays in SHIFT, so any number of bytes can be sent back-to-back in one frame.
    - When `cs_s`=1, return to IDLE. If `bit_cnt`≠0, pulse `frame_err` for one cycle and discard the partial byte; `spi_done` does not fire and `spi_dout` is unchanged.
- Shift direction:
  - `MSB_FIRST`=1: `shreg <= {shreg[6:0], mosi_s}`.
  - `MSB_FIRST`=0: `shreg <= {mosi_s, shreg[7:1]}`.
- Simultaneous `rise` and `cs_s`=1 in the same cycle: `cs_s` wins. The bit is ignored and the partial-frame rule above applies.
- A `rise` while in IDLE is ignored.
- Reset values: `spi_dout`=0x00, `spi_done`=0, `frame_err`=0, `miso`=0, FSM=IDLE, `bit_cnt`=0, `shreg`=0x00.
  - All synchroniser flops reset to the idle pin levels: `sclk` 0, `cs_n` 1, `mosi` 0.
  - Reset asserted mid-byte discards the partial byte and raises no strobes.

## Timing
- Pin-to-`rise` latency: a `sclk` high level first sampled at clk edge N produces `rise` in the cycle after edge N+`SYNC_STAGES`−1.
- `spi_done` is high for exactly one cycle, one edge after the `rise` that carries the 8th bit.
- Total latency is `SYNC_STAGES`+1 clk edges from the first sampling of the 8th `sclk` high level; with the default, 3 edges.
- `mosi` must be stable for ≥ `SYNC_STAGES`+1 clk periods before and after each rising `sclk` edge.
- `sclk` high and low phases must each be ≥ `SYNC_STAGES`+1 clk periods. Behaviour is undefined for faster `sclk`.
- The minimum spacing between `spi_done` strobes is 8 × (`sclk` period in clk cycles), so the consumer never sees strobes in adjacent cycles.

## Configuration
`SPI_ECHO_EN` adds the `miso` port and the following behaviour:
- `spi_dout` is loaded into an 8-bit TX register on `cs_s` falling and on every `spi_done`.
- The TX register is shifted out in the order set by `MSB_FIRST`.
- The first bit is driven on `miso` when `cs_s` falls; subsequent bits update on each `fall`.
- As a result, each byte is echoed to the host during the following byte.
- `miso` is 0 in IDLE.

Without the macro, the `miso` port, the TX register and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold `rst` for 3 cycles with `cs_n`=1 → `spi_dout`=0x00, `spi_done`=0, `frame_err`=0, FSM IDLE.
- Single byte: `cs_n` low, send 0x7F at `sclk` period 16 clk, `cs_n` high → exactly one `spi_done`, `spi_dout`=0x7F held afterwards, no `frame_err`.
- Back-to-back bytes: one frame carrying 0x0C, 0x01, 0x10 → three one-cycle `spi_done` strobes with `spi_dout` = 0x0C, 0x01, 0x10 in order. Downstream `spi_controller` loads `din`/`win`/`bias` with these values.
- Aborted frame: 5 bits of 0xA5, then `cs_n` high → one `frame_err` pulse, no `spi_done`, `spi_dout` unchanged. A following full frame with 0x3C → `spi_dout`=0x3C.
- Reset mid-byte: `rst` asserted after 4 bits → no strobes and `bit_cnt`=0. A following full byte 0x81 → `spi_dout`=0x81.
- With `SPI_ECHO_EN`: send 0x12 then 0x34 in one frame → `miso` sampled by the host on `sclk` rises during the second byte reads 0x12. `MSB_FIRST`=0 run: send 0x01 LSB-first → `spi_dout`=0x01.

Source files
------------

// File: rtl/spi_byte_rx.sv
// spi_byte_rx: SPI mode-0 slave byte receiver. Synchronises sclk/cs_n/mosi
// into the clk domain, deserialises MOSI into bytes, and strobes spi_done
// with each completed byte on spi_dout. frame_err flags a partial byte
// when the frame ends.
// Optional feature macro: SPI_ECHO_EN adds a miso output that echoes each
// received byte back to the host during the following byte.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic [7:0] spi_dout,
  output logic       spi_done,
  output logic       frame_err
`ifdef SPI_ECHO_EN
  ,
  output logic       miso
`endif
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_d;
  logic                   rise;
  logic                   fall;

  state_t     state_q;
  state_t     state_d;
  logic [2:0] bit_cnt;
  logic [2:0] bit_cnt_d;
  logic [7:0] shreg;
  logic [7:0] shreg_d;
  logic [7:0] shifted;
  logic [7:0] dout_d;
  logic       done_d;
  logic       ferr_d;

  // Pin synchronisers; reset to the levels the pins sit at between frames
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_d;
  assign fall   = ~sclk_s & sclk_d;

  // Shift register contents after taking in the current synchronised bit
  always_comb begin
    if (MSB_FIRST) shifted = {shreg[6:0], mosi_s};
    else           shifted = {mosi_s, shreg[7:1]};
  end

  // Receiver state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      spi_dout  <= 8'h00;
      spi_done  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt   <= bit_cnt_d;
      shreg     <= shreg_d;
      spi_dout  <= dout_d;
      spi_done  <= done_d;
      frame_err <= ferr_d;
    end
  end

  // Next state: chip select dominates any coincident sclk rise
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    dout_d    = spi_dout;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_d = 3'd0;
        if (!cs_s) state_d = SHIFT;
      end
      SHIFT: begin
        if (cs_s) begin
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
          if (bit_cnt != 3'd0) ferr_d = 1'b1;
        end else if (rise) begin
          shreg_d   = shifted;
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            dout_d = shifted;
            done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SPI_ECHO_EN
  logic [7:0] tx_reg;

  // Echo path: first bit goes out when the frame opens, the rest on sclk falls
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_reg <= 8'h00;
      miso   <= 1'b0;
    end else if (state_q == IDLE) begin
      if (!cs_s) begin
        miso   <= MSB_FIRST ? spi_dout[7] : spi_dout[0];
        tx_reg <= MSB_FIRST ? {spi_dout[6:0], 1'b0} : {1'b0, spi_dout[7:1]};
      end else begin
        miso   <= 1'b0;
      end
    end else if (cs_s) begin
      miso <= 1'b0;
    end else if (spi_done) begin
      tx_reg <= spi_dout;
    end else if (fall) begin
      miso   <= MSB_FIRST ? tx_reg[7] : tx_reg[0];
      tx_reg <= MSB_FIRST ? {tx_reg[6:0], 1'b0} : {1'b0, tx_reg[7:1]};
    end
  end
`endif

endmodule

// File: tb/tb_spi_byte_rx.sv
// Directed testbench for spi_byte_rx: an MSB-first and an LSB-first
// instance share the same SPI pins; a monitor records strobes.
module tb_spi_byte_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic [7:0] spi_dout;
  logic       spi_done;
  logic       frame_err;
  logic       miso_w;
  logic [7:0] lsb_dout;
  logic       lsb_done;
  logic       lsb_ferr;

  int         errors = 0;
  int         checks = 0;
  int         done_cnt = 0;
  int         ferr_cnt = 0;
  logic [7:0] done_bytes[$];
  bit         done_adjacent = 1'b0;
  logic       prev_done = 1'b0;

  spi_byte_rx #(.SYNC_STAGES(2), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .spi_dout(spi_dout), .spi_done(spi_done), .frame_err(frame_err)
`ifdef SPI_ECHO_EN
    , .miso(miso_w)
`endif
  );

`ifdef SPI_ECHO_EN
  logic lsb_miso;
`else
  assign miso_w = 1'b0;
`endif

  spi_byte_rx #(.SYNC_STAGES(2), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .spi_dout(lsb_dout), .spi_done(lsb_done), .frame_err(lsb_ferr)
`ifdef SPI_ECHO_EN
    , .miso(lsb_miso)
`endif
  );

  always #5 clk = ~clk;

  // Strobe monitor sampled on the inactive clock edge
  always @(negedge clk) begin
    if (spi_done) begin
      done_cnt++;
      done_bytes.push_back(spi_dout);
      if (prev_done) done_adjacent = 1'b1;
    end
    if (frame_err) ferr_cnt++;
    prev_done = spi_done;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    done_cnt = 0;
    ferr_cnt = 0;
    done_bytes.delete();
    done_adjacent = 1'b0;
  endtask

  task automatic send_bit(input logic b, output logic m);
    mosi = b;
    wait_clks(8);
    sclk = 1'b1;
    m = miso_w;
    wait_clks(8);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit lsb_first, output logic [7:0] echo);
    logic m;
    echo = 8'h00;
    for (int i = 0; i < 8; i++) begin
      send_bit(lsb_first ? b[i] : b[7-i], m);
      echo = {echo[6:0], m};
    end
  endtask

  task automatic frame_start();
    cs_n = 1'b0;
    wait_clks(8);
  endtask

  task automatic frame_end();
    wait_clks(4);
    cs_n = 1'b1;
    wait_clks(12);
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(2);
    checks++; if (spi_dout !== 8'h00) begin errors++; $display("[TB] FAIL reset_dout: got %h want 00", spi_dout); end
    checks++; if (spi_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", spi_done); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr: got %b want 0", frame_err); end
    checks++; if (dut.bit_cnt !== 3'd0) begin errors++; $display("[TB] FAIL reset_bitcnt: got %0d want 0", dut.bit_cnt); end
    checks++; if (miso_w !== 1'b0) begin errors++; $display("[TB] FAIL reset_miso: got %b want 0", miso_w); end
  endtask

  task automatic test_single_byte();
    logic [7:0] e;
    clear_mon();
    frame_start();
    send_byte(8'h7F, 1'b0, e);
    frame_end();
    checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL single_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (done_bytes.size() < 1 || done_bytes[0] !== 8'h7F) begin errors++; $display("[TB] FAIL single_strobe_byte: got size %0d want 7f", done_bytes.size()); end
    checks++; if (spi_dout !== 8'h7F) begin errors++; $display("[TB] FAIL single_dout_held: got %h want 7f", spi_dout); end
    checks++; if (ferr_cnt !== 0) begin errors++; $display("[TB] FAIL single_ferr: got %0d want 0", ferr_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h0C; exp_b[1] = 8'h01; exp_b[2] = 8'h10;
    clear_mon();
    frame_start();
    for (int i = 0; i < 3; i++) send_byte(exp_b[i], 1'b0, e);
    frame_end();
    checks++; if (done_cnt !== 3) begin errors++; $display("[TB] FAIL b2b_done_cnt: got %0d want 3", done_cnt); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (done_bytes.size() <= i || done_bytes[i] !== exp_b[i]) begin
        errors++; $display("[TB] FAIL b2b_byte%0d: got size %0d want %h", i, done_bytes.size(), exp_b[i]);
      end
    end
    checks++; if (done_adjacent) begin errors++; $display("[TB] FAIL b2b_done_width: got adjacent strobes want single-cycle"); end
    checks++; if (ferr_cnt !== 0) begin errors++; $display("[TB] FAIL b2b_ferr: got %0d want 0", ferr_cnt); end
  endtask

  task automatic test_aborted_frame();
    logic [7:0] e;
    logic       m;
    logic [7:0] partial;
    partial = 8'hA5;
    clear_mon();
    frame_start();
    for (int i = 7; i >= 3; i--) send_bit(partial[i], m);
    frame_end();
    checks++; if (ferr_cnt !== 1) begin errors++; $display("[TB] FAIL abort_ferr_cnt: got %0d want 1", ferr_cnt); end
    checks++; if (done_cnt !== 0) begin errors++; $display("[TB] FAIL abort_done_cnt: got %0d want 0", done_cnt); end
    checks++; if (spi_dout !== 8'h10) begin errors++; $display("[TB] FAIL abort_dout_kept: got %h want 10", spi_dout); end
    frame_start();
    send_byte(8'h3C, 1'b0, e);
    frame_end();
    checks++; if (spi_dout !== 8'h3C) begin errors++; $display("[TB] FAIL abort_next_dout: got %h want 3c", spi_dout); end
    checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL abort_next_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] e;
    logic       m;
    clear_mon();
    frame_start();
    send_bit(1'b1, m); send_bit(1'b0, m); send_bit(1'b1, m); send_bit(1'b0, m);
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(1);
    checks++; if (dut.bit_cnt !== 3'd0) begin errors++; $display("[TB] FAIL midrst_bitcnt: got %0d want 0", dut.bit_cnt); end
    checks++; if (spi_dout !== 8'h00) begin errors++; $display("[TB] FAIL midrst_dout: got %h want 00", spi_dout); end
    wait_clks(8);
    checks++; if (done_cnt !== 0 || ferr_cnt !== 0) begin errors++; $display("[TB] FAIL midrst_strobes: got done=%0d ferr=%0d want 0/0", done_cnt, ferr_cnt); end
    send_byte(8'h81, 1'b0, e);
    frame_end();
    checks++; if (spi_dout !== 8'h81) begin errors++; $display("[TB] FAIL midrst_next_dout: got %h want 81", spi_dout); end
    checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL midrst_next_done: got %0d want 1", done_cnt); end
    checks++; if (ferr_cnt !== 0) begin errors++; $display("[TB] FAIL midrst_next_ferr: got %0d want 0", ferr_cnt); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] e;
    clear_mon();
    frame_start();
    send_byte(8'h01, 1'b1, e);
    frame_end();
    checks++; if (lsb_dout !== 8'h01) begin errors++; $display("[TB] FAIL lsb_dout: got %h want 01", lsb_dout); end
    checks++; if (spi_dout !== 8'h80) begin errors++; $display("[TB] FAIL lsb_stream_on_msb: got %h want 80", spi_dout); end
  endtask

`ifdef SPI_ECHO_EN
  task automatic test_echo();
    logic [7:0] e1;
    logic [7:0] e2;
    frame_start();
    send_byte(8'h12, 1'b0, e1);
    send_byte(8'h34, 1'b0, e2);
    frame_end();
    checks++; if (e1 !== 8'h80) begin errors++; $display("[TB] FAIL echo_first: got %h want 80", e1); end
    checks++; if (e2 !== 8'h12) begin errors++; $display("[TB] FAIL echo_second: got %h want 12", e2); end
    checks++; if (miso_w !== 1'b0) begin errors++; $display("[TB] FAIL echo_idle_miso: got %b want 0", miso_w); end
  endtask
`endif

  initial begin
    $display("[TB] spi_byte_rx directed test start");
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_aborted_frame();
    test_reset_mid_byte();
    test_lsb_first();
`ifdef SPI_ECHO_EN
    test_echo();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
